// File: rtl/mod_dds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_dds_pkg
// Brief    : Shared mode encodings, quadrant type and midscale helper for the
//            multi-mode DDS.
// Revision : 1.0
// ============================================================================
package mod_dds_pkg;

  localparam logic [1:0] MODE_OOK  = 2'd0;
  localparam logic [1:0] MODE_BFSK = 2'd1;
  localparam logic [1:0] MODE_BPSK = 2'd2;
  localparam logic [1:0] MODE_CW   = 2'd3;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  function automatic int midscale(input int dac_w);
    return 1 << (dac_w - 1);
  endfunction

endpackage : mod_dds_pkg
`default_nettype wire

// File: rtl/dds_quarter_sine_lut.sv
`default_nettype none
// ============================================================================
// Module   : dds_quarter_sine_lut
// Brief    : Combinational quarter-wave sine table, lut[k] =
//            round(M + M*sin(pi/2 * k/Q)), built at elaboration.
// Revision : 1.0
// ============================================================================
module dds_quarter_sine_lut #(
  parameter int PHASE_W = 8,
  parameter int DAC_W   = 8
) (
  input  logic [PHASE_W-3:0] idx_i,
  output logic [DAC_W-1:0]   val_o
);

  localparam int  c_Q       = 2 ** (PHASE_W - 2);
  localparam real c_M       = real'((2 ** (DAC_W - 1)) - 1);
  localparam real c_HALF_PI = 1.5707963267948966;

  // Taylor series keeps the table independent of simulator math builtins.
  function automatic real f_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  logic [DAC_W-1:0] tbl [c_Q];

  for (genvar k = 0; k < c_Q; k++) begin : g_entry
    localparam real c_ANG = c_HALF_PI * real'(k) / real'(c_Q);
    localparam int  c_VAL = $rtoi(c_M + c_M * f_sin(c_ANG) + 0.5);
    assign tbl[k] = DAC_W'(c_VAL);
  end

  assign val_o = tbl[idx_i];

endmodule : dds_quarter_sine_lut
`default_nettype wire

// File: rtl/mod_dds.sv
`default_nettype none
// ============================================================================
// Module   : mod_dds
// Brief    : OOK/BFSK/BPSK/CW direct digital synthesiser with double-buffered
//            frequency words committed at accumulator wrap.
//            Optional amplitude ramp: define MOD_DDS_AMP_RAMP_EN.
// Revision : 1.0
// ============================================================================
module mod_dds
  import mod_dds_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter int               PHASE_W     = 8,
  parameter int               DAC_W       = 8,
  parameter logic [ACC_W-1:0] FTW_DEFAULT = ACC_W'(32'h0100_0000),
  parameter int               RAMP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ftw_wr_i,
  input  logic             ftw_sel_i,
  input  logic [ACC_W-1:0] ftw_data_i,
  input  logic [1:0]       mode_i,
  input  logic             data_in_i,
  output logic             ftw_pending_o,
  output logic [DAC_W-1:0] dac_o,
  output logic             dac_valid_o
);

  localparam int               c_IDX_W = PHASE_W - 2;
  localparam logic [DAC_W-1:0] c_MID   = DAC_W'(midscale(DAC_W));
`ifdef MOD_DDS_AMP_RAMP_EN
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 2 + 0 * RAMP_W;
`endif

  logic [ACC_W-1:0] acc_q, acc_d, inc;
  logic [ACC_W-1:0] act0_q, act1_q, sh0_q, sh1_q;
  logic             wrap, pend_q, data_q;

  always_comb begin
    inc = (mode_i == MODE_BFSK && data_q) ? act1_q : act0_q;
    {wrap, acc_d} = {1'b0, acc_q} + {1'b0, inc};
  end

  // Shadows written at an edge are not visible to a commit at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      act0_q <= FTW_DEFAULT;
      act1_q <= FTW_DEFAULT;
      sh0_q  <= FTW_DEFAULT;
      sh1_q  <= FTW_DEFAULT;
      pend_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_in_i;
      if (wrap) begin
        act0_q <= sh0_q;
        act1_q <= sh1_q;
      end
      if (ftw_wr_i) begin
        if (ftw_sel_i) sh1_q <= ftw_data_i;
        else           sh0_q <= ftw_data_i;
      end
      if (ftw_wr_i)  pend_q <= 1'b1;
      else if (wrap) pend_q <= 1'b0;
    end
  end

  // Stage 1: truncated phase, BPSK inversion, quadrant split, OOK gate.
  logic [PHASE_W-1:0] phase;
  quad_e              quad_q;
  logic [c_IDX_W-1:0] idx_q;
  logic               gate_q;
  logic               ook_q;

  always_comb begin
    phase = acc_q[ACC_W-1 -: PHASE_W];
    if (mode_i == MODE_BPSK && data_q) phase[PHASE_W-1] = ~phase[PHASE_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quad_q <= QUAD_0;
      idx_q  <= '0;
      gate_q <= 1'b0;
      ook_q  <= 1'b0;
    end else begin
      quad_q <= quad_e'(phase[PHASE_W-1 -: 2]);
      idx_q  <= phase[c_IDX_W-1:0];
      gate_q <= !(mode_i == MODE_OOK && !data_q);
      ook_q  <= (mode_i == MODE_OOK);
    end
  end

  // Stage 2: fold into the quarter table; ~x equals (all-ones - x).
  logic [c_IDX_W-1:0] fold_idx;
  logic [DAC_W-1:0]   lut_val, s_d;

  always_comb begin
    fold_idx = (quad_q == QUAD_1 || quad_q == QUAD_3) ? ~idx_q : idx_q;
    s_d      = (quad_q == QUAD_2 || quad_q == QUAD_3) ? ~lut_val : lut_val;
  end

  dds_quarter_sine_lut #(
    .PHASE_W (PHASE_W),
    .DAC_W   (DAC_W)
  ) u_lut (
    .idx_i (fold_idx),
    .val_o (lut_val)
  );

  logic [DAC_W-1:0] dac_q;

`ifdef MOD_DDS_AMP_RAMP_EN
  localparam int               c_FULL_I = 2 ** RAMP_W;
  localparam logic [RAMP_W:0]  c_FULL   = c_FULL_I[RAMP_W:0];
  localparam int               c_PW     = DAC_W + RAMP_W + 3;

  logic [DAC_W-1:0]        s2_q;
  logic [RAMP_W:0]         amp_q, amp_d;
  logic signed [DAC_W:0]   diff;
  logic signed [c_PW-1:0]  prod;
  logic [DAC_W-1:0]        ramp_out;

  always_comb begin
    amp_d = amp_q;
    if (!ook_q)                          amp_d = c_FULL;
    else if (gate_q && amp_q != c_FULL)  amp_d = amp_q + 1'b1;
    else if (!gate_q && amp_q != '0)     amp_d = amp_q - 1'b1;
  end

  always_comb begin
    diff     = $signed({1'b0, s2_q}) - $signed({1'b0, c_MID});
    prod     = c_PW'(diff) * c_PW'($signed({1'b0, amp_q}));
    ramp_out = c_MID + DAC_W'(prod >>> RAMP_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q  <= c_MID;
      amp_q <= '0;
      dac_q <= c_MID;
    end else begin
      s2_q  <= s_d;
      amp_q <= amp_d;
      dac_q <= ramp_out;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) dac_q <= c_MID;
    else     dac_q <= gate_q ? s_d : c_MID;
  end
`endif

  logic [c_LAT-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[c_LAT-2:0], 1'b1};
  end

  assign dac_o         = dac_q;
  assign dac_valid_o   = vld_q[c_LAT-1];
  assign ftw_pending_o = pend_q;

endmodule : mod_dds
`default_nettype wire

// File: tb/tb_mod_dds.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mod_dds
// Brief    : Self-checking bench for mod_dds against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mod_dds;

  localparam logic [31:0] c_DEF = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ftw_wr = 1'b0;
  logic        ftw_sel = 1'b0;
  logic [31:0] ftw_data = '0;
  logic [1:0]  mode = 2'd3;
  logic        data_in = 1'b0;
  logic        ftw_pending;
  logic [7:0]  dac;
  logic        dac_valid;

  always #5 clk = ~clk;

  mod_dds dut (
    .clk           (clk),
    .rst           (rst),
    .ftw_wr_i      (ftw_wr),
    .ftw_sel_i     (ftw_sel),
    .ftw_data_i    (ftw_data),
    .mode_i        (mode),
    .data_in_i     (data_in),
    .ftw_pending_o (ftw_pending),
    .dac_o         (dac),
    .dac_valid_o   (dac_valid)
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  int          lut [64];
  logic [31:0] m_acc;
  logic [31:0] m_act [2];
  logic [31:0] m_sh  [2];
  logic        m_pend, m_data;
  logic [7:0]  m_s1, m_dac;
  int          m_vcnt;

  // Expected sample for an accumulator value, straight from the waveform rules.
  function automatic logic [7:0] expect_sample(input logic [31:0] acc,
                                               input logic [1:0] md,
                                               input logic d);
    int p, q, i, idx, s;
    p = int'(acc[31:24]);
    if (md == 2'd2 && d) p = (p + 128) % 256;
    if (md == 2'd0 && !d) return 8'd128;
    q   = p / 64;
    i   = p % 64;
    idx = (q % 2 == 1) ? 63 - i : i;
    s   = lut[idx];
    if (q >= 2) s = 255 - s;
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [32:0] sum;
    logic [31:0] inc;
    @(posedge clk);
    if (rst) begin
      m_acc  = '0;
      m_act[0] = c_DEF; m_act[1] = c_DEF;
      m_sh[0]  = c_DEF; m_sh[1]  = c_DEF;
      m_pend = 1'b0;
      m_data = 1'b0;
      m_s1   = 8'd128;
      m_dac  = 8'd128;
      m_vcnt = 0;
      ncyc   = 0;
    end else begin
      m_dac = m_s1;
      m_s1  = expect_sample(m_acc, mode, m_data);
      inc   = (mode == 2'd1 && m_data) ? m_act[1] : m_act[0];
      sum   = {1'b0, m_acc} + {1'b0, inc};
      m_acc = sum[31:0];
      if (sum[32]) begin
        m_act[0] = m_sh[0];
        m_act[1] = m_sh[1];
      end
      if (ftw_wr) m_sh[ftw_sel] = ftw_data;
      if (ftw_wr)       m_pend = 1'b1;
      else if (sum[32]) m_pend = 1'b0;
      m_data = data_in;
      if (m_vcnt < 2) m_vcnt++;
      ncyc++;
    end
    #1;
    chk("dac", 32'(dac), 32'(m_dac));
    chk("dac_valid", 32'(dac_valid), 32'(m_vcnt >= 2));
    chk("ftw_pending", 32'(ftw_pending), 32'(m_pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pend_clear(input string tag);
    for (int k = 0; k < 600 && ftw_pending; k++) tick();
    chk(tag, 32'(ftw_pending), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi(127.0 + 127.0 * $sin(3.14159265358979 * real'(k) / 128.0) + 0.5);

    // Reset state and CW reference points.
    mode = 2'd3;
    rst  = 1'b1;
    repeat (3) tick();
    chk("reset_dac", 32'(dac), 32'h80);
    chk("reset_valid", 32'(dac_valid), 32'd0);
    rst = 1'b0;
    repeat (260) begin
      data_in = 1'($urandom);
      tick();
      if (ncyc == 1)   chk("cw_valid_c1", 32'(dac_valid), 32'd0);
      if (ncyc == 2)   chk("cw_ph0", 32'(dac), 32'h7F);
      if (ncyc == 66)  chk("cw_ph64", 32'(dac), 32'hFE);
      if (ncyc == 130) chk("cw_ph128", 32'(dac), 32'h80);
      if (ncyc == 194) chk("cw_ph192", 32'(dac), 32'h01);
      if (ncyc == 258) chk("cw_period", 32'(dac), 32'h7F);
    end

    // OOK with 32-cycle bit windows.
    mode = 2'd0;
    for (int k = 0; k < 192; k++) begin
      data_in = 1'((k / 32) % 2);
      tick();
    end

    // BFSK with FTW1 = 2^25.
    mode     = 2'd1;
    ftw_wr   = 1'b1;
    ftw_sel  = 1'b1;
    ftw_data = 32'h0200_0000;
    tick();
    ftw_wr = 1'b0;
    chk("bfsk_pend_set", 32'(ftw_pending), 32'd1);
    wait_pend_clear("bfsk_commit");
    for (int k = 0; k < 320; k++) begin
      if (k % 24 == 0) data_in = 1'($urandom);
      tick();
    end

    // BPSK: phase 32 unflipped vs flipped.
    mode    = 2'd2;
    data_in = 1'b0;
    do_reset();
    repeat (34) tick();
    chk("bpsk_d0", 32'(dac), 32'hD9);
    data_in = 1'b1;
    do_reset();
    repeat (34) tick();
    chk("bpsk_d1", 32'(dac), 32'h26);

    // Mid-period write, then a write landing on the wrap edge.
    mode    = 2'd3;
    data_in = 1'b0;
    do_reset();
    repeat (100) tick();
    ftw_wr   = 1'b1;
    ftw_sel  = 1'b0;
    ftw_data = 32'h0200_0000;
    tick();
    ftw_wr = 1'b0;
    chk("mid_pend_set", 32'(ftw_pending), 32'd1);
    wait_pend_clear("mid_commit");
    for (int k = 0; k < 300 && (({1'b0, m_acc} + {1'b0, m_act[0]}) < 33'h1_0000_0000); k++)
      tick();
    ftw_wr   = 1'b1;
    ftw_data = 32'h0100_0000;
    tick();
    ftw_wr = 1'b0;
    chk("wrap_pend_set", 32'(ftw_pending), 32'd1);
    repeat (64) tick();
    chk("wrap_pend_hold", 32'(ftw_pending), 32'd1);
    wait_pend_clear("wrap_commit");

    // Randomised mix of modes, data, writes and occasional reset.
    for (int k = 0; k < 800; k++) begin
      if (k % 16 == 0) mode = 2'($urandom_range(0, 3));
      data_in  = 1'($urandom);
      ftw_wr   = ($urandom_range(0, 15) == 0);
      ftw_sel  = 1'($urandom);
      ftw_data = 32'($urandom_range(32'h0040_0000, 32'h0800_0000));
      rst      = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst    = 1'b0;
    ftw_wr = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_dds
`default_nettype wire
